// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, two write ports, reserve request and scoreboard view.
interface regfile_mp_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ADDR_W   = 6
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rs_addr;
  logic [NUM_RD*DATA_W-1:0] rs_data;
  logic [NUM_RD-1:0]        rs_busy;
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [NUM_REGS-1:0]      busy_vec;

  modport master (
    output rd_en, rs_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           rsv_en, rsv_addr,
    input  rs_data, rs_busy, busy_vec
  );

  modport slave (
    input  rd_en, rs_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           rsv_en, rsv_addr,
    output rs_data, rs_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file (x0 hardwired to zero) with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/busy into the read registers.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ADDR_W   = 6
) (
  input logic        clk,
  input logic        rst,
  regfile_mp_if.slave bus
);

  logic [DATA_W-1:0]        mem [1:NUM_REGS-1];
  logic [NUM_REGS-1:0]      busy_q;
  logic [NUM_REGS-1:0]      busy_nxt;
  logic [NUM_REGS-1:0]      wa_sel;
  logic [NUM_REGS-1:0]      wb_sel;
  logic [NUM_REGS-1:0]      rsv_sel;
  logic [DATA_W-1:0]        rd_d [NUM_RD];
  logic [NUM_RD-1:0]        rb_d;
  logic [NUM_RD*DATA_W-1:0] rs_data_q;
  logic [NUM_RD-1:0]        rs_busy_q;

  // Decoding only indices 1..NUM_REGS-1 drops x0 and out-of-range addresses.
  always_comb begin
    wa_sel  = '0;
    wb_sel  = '0;
    rsv_sel = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      wa_sel[i]  = bus.wa_en  && (bus.wa_addr  == ADDR_W'(i));
      wb_sel[i]  = bus.wb_en  && (bus.wb_addr  == ADDR_W'(i));
      rsv_sel[i] = bus.rsv_en && (bus.rsv_addr == ADDR_W'(i));
    end
  end

  // Reserve is applied after the write-clear so it wins on a collision.
  assign busy_nxt = (busy_q & ~(wa_sel | wb_sel)) | rsv_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) mem[i] <= '0;
    end else begin
      busy_q <= busy_nxt;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (wb_sel[i])      mem[i] <= bus.wb_data;
        else if (wa_sel[i]) mem[i] <= bus.wa_data;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_d[k] = '0;
      rb_d[k] = 1'b0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (bus.rs_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
`ifdef REGFILE_BYPASS_EN
          if (wb_sel[i])      rd_d[k] = bus.wb_data;
          else if (wa_sel[i]) rd_d[k] = bus.wa_data;
          else                rd_d[k] = mem[i];
          rb_d[k] = busy_nxt[i];
`else
          rd_d[k] = mem[i];
          rb_d[k] = busy_q[i];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_data_q <= '0;
      rs_busy_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_RD; k++) begin
        if (bus.rd_en[k]) begin
          rs_data_q[k*DATA_W +: DATA_W] <= rd_d[k];
          rs_busy_q[k]                  <= rb_d[k];
        end
      end
    end
  end

  assign bus.rs_data  = rs_data_q;
  assign bus.rs_busy  = rs_busy_q;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp; read expectations are queued at issue and checked one cycle later.
module tb_regfile_mp;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned NP = 2;
  localparam int unsigned AW = 6;

  typedef struct {
    string       tag;
    int unsigned port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NP), .ADDR_W(AW)) bus ();

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NP), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rst         = 1'b0;
    bus.rd_en   = '0;
    bus.wa_en   = 1'b0;
    bus.wb_en   = 1'b0;
    bus.rsv_en  = 1'b0;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    clear_inputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, "_data"}, 64'(bus.rs_data[e.port*DW +: DW]), 64'(e.data));
      chk({e.tag, "_busy"}, 64'(bus.rs_busy[e.port]), 64'(e.busy));
    end
  endtask

  task automatic rd(input int unsigned p, input logic [AW-1:0] a,
                    input logic [31:0] d, input logic b, input string tag);
    exp_t e;
    bus.rd_en[p]            = 1'b1;
    bus.rs_addr[p*AW +: AW] = a;
    e.tag  = tag;
    e.port = p;
    e.data = d;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic wa(input logic [AW-1:0] a, input logic [31:0] d);
    bus.wa_en = 1'b1; bus.wa_addr = a; bus.wa_data = d;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [31:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    bus.rsv_en = 1'b1; bus.rsv_addr = a;
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    errors = 0;
    bus.rs_addr = '0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_addr = '0; bus.wb_data = '0; bus.rsv_addr = '0;
    clear_inputs();
    rst = 1'b1;
    tick();
    chk("init_busy_vec", 64'(bus.busy_vec), 64'd0);
    chk("init_rs_data", 64'(bus.rs_data), 64'd0);
    chk("init_rs_busy", 64'(bus.rs_busy), 64'd0);

    // Reset clears non-zero state
    wa(6'd4, 32'h0000_0077); rsv(6'd6); tick();
    rd(1, 6'd4, 32'h0000_0077, 1'b0, "pre_rst_x4");
    rd(0, 6'd6, 32'h0, 1'b1, "pre_rst_x6");
    tick();
    chk("pre_rst_busy_vec", 64'(bus.busy_vec), 64'h40);
    rst = 1'b1; tick();
    chk("rst_busy_vec", 64'(bus.busy_vec), 64'd0);
    chk("rst_rs_data", 64'(bus.rs_data), 64'd0);
    chk("rst_rs_busy", 64'(bus.rs_busy), 64'd0);
    rd(0, 6'd4, 32'h0, 1'b0, "post_rst_x4");
    tick();

    // Write then read with one-cycle latency
    wa(6'd5, 32'hDEAD_BEEF); tick();
    rd(0, 6'd5, 32'hDEAD_BEEF, 1'b0, "rd_x5");
    tick();

    // x0 hardwired, port B wins on conflict
    wa(6'd0, 32'h0000_1234); tick();
    wa(6'd7, 32'h11); wb(6'd7, 32'h22); tick();
    rd(0, 6'd0, 32'h0, 1'b0, "rd_x0");
    rd(1, 6'd7, 32'h22, 1'b0, "rd_x7_conflict");
    tick();

    // Out-of-range address ignored for write, reserve and read
    wa(6'd40, 32'hFF); rsv(6'd40); tick();
    chk("oor_busy_vec", 64'(bus.busy_vec), 64'd0);
    rd(0, 6'd40, 32'h0, 1'b0, "rd_oor");
    tick();

    // Scoreboard set/clear and reserve-over-write priority
    rsv(6'd9); tick();
    chk("rsv_x9", 64'(bus.busy_vec), 64'h200);
    wb(6'd9, 32'h55); tick();
    chk("wb_clr_x9", 64'(bus.busy_vec), 64'd0);
    rd(1, 6'd9, 32'h55, 1'b0, "rd_x9_55");
    tick();
    rsv(6'd9); wa(6'd9, 32'h66); tick();
    chk("rsv_wins_x9", 64'(bus.busy_vec), 64'h200);
    rd(0, 6'd9, 32'h66, 1'b1, "rd_x9_66");
    tick();

    // Same-cycle read/write
    wa(6'd3, 32'hA); tick();
`ifdef REGFILE_BYPASS_EN
    wa(6'd3, 32'hB); rd(0, 6'd3, 32'hB, 1'b0, "rw_same_x3");
    tick();
    rsv(6'd10); rd(1, 6'd10, 32'h0, 1'b1, "rsv_same_x10");
    tick();
    wa(6'd10, 32'h5A); rd(0, 6'd10, 32'h5A, 1'b0, "wclr_same_x10");
    tick();
`else
    wa(6'd3, 32'hB); rd(0, 6'd3, 32'hA, 1'b0, "rw_same_x3");
    tick();
    rsv(6'd10); rd(1, 6'd10, 32'h0, 1'b0, "rsv_same_x10");
    tick();
    wa(6'd10, 32'h5A); rd(0, 6'd10, 32'h0, 1'b1, "wclr_same_x10");
    tick();
`endif
    rd(0, 6'd3, 32'hB, 1'b0, "rd_x3_after");
    rd(1, 6'd10, 32'h5A, 1'b0, "rd_x10_after");
    tick();

    // Hold when rd_en is low
    rd(0, 6'd5, 32'hDEAD_BEEF, 1'b0, "hold_setup_x5");
    tick();
    bus.rs_addr = {6'd9, 6'd7}; tick();
    chk("hold_port0", 64'(bus.rs_data[0 +: DW]), 64'hDEAD_BEEF);
    chk("hold_port1", 64'(bus.rs_data[DW +: DW]), 64'h5A);

    // Reset during a write and a reserve
    wb(6'd12, 32'h99); rsv(6'd13); rst = 1'b1; tick();
    chk("midrst_busy_vec", 64'(bus.busy_vec), 64'd0);
    rd(0, 6'd12, 32'h0, 1'b0, "midrst_x12");
    rd(1, 6'd9, 32'h0, 1'b0, "midrst_x9");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
